logic_capture_ctrl: RTL and testbench

Capture sequencer that sits in front of logic_capture_fifo in the logic-analyser core. It divides the system clock into a sample strobe and watches the 32 input channels for a mask/value trigger, level or edge. Once triggered, it pushes a programmed number of samples into the FIFO and reports state, sample count and overflow to the register interface.

---
 rtl/logic_capture_ctrl.sv | 170 +++++++++++++++++
 tb/tb_logic_capture_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_capture_ctrl.sv
`default_nettype none
// ============================================================================
// logic_capture_ctrl: sample-rate divider, mask/value trigger and capture
// sequencer feeding logic_capture_fifo.   Rev 1.0
// ============================================================================
module logic_capture_ctrl #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_enable_i,
  input  logic [DIV_W-1:0] cfg_clk_div_i,
  input  logic [31:0]      cfg_trig_mask_i,
  input  logic [31:0]      cfg_trig_value_i,
  input  logic             cfg_trig_edge_i,
  input  logic [31:0]      cfg_samples_i,
  input  logic [31:0]      input_i,
  output logic [31:0]      fifo_data_o,
  output logic             fifo_push_o,
  input  logic             fifo_accept_i,
  output logic [1:0]       status_state_o,
  output logic             status_triggered_o,
  output logic             status_overflow_o,
  output logic [31:0]      status_count_o
);

  localparam logic [1:0] C_IDLE    = 2'd0;
  localparam logic [1:0] C_ARMED   = 2'd1;
  localparam logic [1:0] C_CAPTURE = 2'd2;
  localparam logic [1:0] C_DONE    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [31:0]      mask_q, mask_d;
  logic [31:0]      value_q, value_d;
  logic             edge_q, edge_d;
  logic [31:0]      samples_q, samples_d;
  logic             prev_match_q, prev_match_d;
  logic [31:0]      count_q, count_d;
  logic             triggered_q, triggered_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      fifo_data_q, fifo_data_d;
  logic             fifo_push_q, fifo_push_d;

  logic        w_running;
  logic        w_strobe;
  logic        w_match;
  logic        w_trig;
  logic        w_last;
  logic [31:0] w_count_inc;

  always_comb begin
    w_running   = (state_q == C_ARMED) || (state_q == C_CAPTURE);
    w_strobe    = w_running && (div_cnt_q == div_q);
    w_match     = ((input_i ^ value_q) & mask_q) == 32'd0;
    w_trig      = edge_q ? (w_match && !prev_match_q) : w_match;
    w_count_inc = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
    // Sample that completes the programmed run; 0 means continuous.
    w_last      = (samples_q != 32'd0) &&
                  (({1'b0, count_q} + 33'd1) == {1'b0, samples_q});

    state_d      = state_q;
    div_d        = div_q;
    mask_d       = mask_q;
    value_d      = value_q;
    edge_d       = edge_q;
    samples_d    = samples_q;
    prev_match_d = prev_match_q;
    count_d      = count_q;
    triggered_d  = triggered_q;
    overflow_d   = overflow_q;
    fifo_data_d  = fifo_data_q;
    fifo_push_d  = 1'b0;
    div_cnt_d    = w_running ? (w_strobe ? '0 : div_cnt_q + 1'b1) : '0;

    if (fifo_push_q && !fifo_accept_i) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      C_IDLE: begin
        if (cfg_enable_i) begin
          state_d      = C_ARMED;
          div_d        = cfg_clk_div_i;
          mask_d       = cfg_trig_mask_i;
          value_d      = cfg_trig_value_i;
          edge_d       = cfg_trig_edge_i;
          samples_d    = cfg_samples_i;
          prev_match_d = 1'b0;
          count_d      = 32'd0;
          triggered_d  = 1'b0;
          overflow_d   = 1'b0;
        end
      end
      C_ARMED: begin
        if (!cfg_enable_i) begin
          state_d = C_IDLE;
        end else if (w_strobe) begin
          prev_match_d = w_match;
          if (w_trig) begin
            triggered_d = 1'b1;
            fifo_push_d = 1'b1;
            fifo_data_d = input_i;
            count_d     = w_count_inc;
            state_d     = w_last ? C_DONE : C_CAPTURE;
          end
        end
      end
      C_CAPTURE: begin
        if (!cfg_enable_i) begin
          state_d = C_IDLE;
        end else if (w_strobe) begin
          fifo_push_d = 1'b1;
          fifo_data_d = input_i;
          count_d     = w_count_inc;
          if (w_last) begin
            state_d = C_DONE;
          end
        end
      end
      default: begin
        if (!cfg_enable_i) begin
          state_d = C_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= C_IDLE;
      div_q        <= '0;
      div_cnt_q    <= '0;
      mask_q       <= 32'd0;
      value_q      <= 32'd0;
      edge_q       <= 1'b0;
      samples_q    <= 32'd0;
      prev_match_q <= 1'b0;
      count_q      <= 32'd0;
      triggered_q  <= 1'b0;
      overflow_q   <= 1'b0;
      fifo_data_q  <= 32'd0;
      fifo_push_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      div_cnt_q    <= div_cnt_d;
      mask_q       <= mask_d;
      value_q      <= value_d;
      edge_q       <= edge_d;
      samples_q    <= samples_d;
      prev_match_q <= prev_match_d;
      count_q      <= count_d;
      triggered_q  <= triggered_d;
      overflow_q   <= overflow_d;
      fifo_data_q  <= fifo_data_d;
      fifo_push_q  <= fifo_push_d;
    end
  end

  assign fifo_data_o        = fifo_data_q;
  assign fifo_push_o        = fifo_push_q;
  assign status_state_o     = state_q;
  assign status_triggered_o = triggered_q;
  assign status_overflow_o  = overflow_q;
  assign status_count_o     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_capture_ctrl.sv
`default_nettype none
// ============================================================================
// tb_logic_capture_ctrl: directed and randomized capture runs checked against
// a run-level reference model.   Rev 1.0
// ============================================================================
module tb_logic_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable;
  logic [15:0] cfg_clk_div;
  logic [31:0] cfg_trig_mask;
  logic [31:0] cfg_trig_value;
  logic        cfg_trig_edge;
  logic [31:0] cfg_samples;
  logic [31:0] input_w;
  logic [31:0] fifo_data;
  logic        fifo_push;
  logic        fifo_accept;
  logic [1:0]  status_state;
  logic        status_triggered;
  logic        status_overflow;
  logic [31:0] status_count;

  int tests = 0;
  int fails = 0;
  int accepted;

  logic [31:0] inp [0:199];
  bit          acc [0:199];

  logic_capture_ctrl #(.DIV_W(16)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .cfg_enable_i       (cfg_enable),
    .cfg_clk_div_i      (cfg_clk_div),
    .cfg_trig_mask_i    (cfg_trig_mask),
    .cfg_trig_value_i   (cfg_trig_value),
    .cfg_trig_edge_i    (cfg_trig_edge),
    .cfg_samples_i      (cfg_samples),
    .input_i            (input_w),
    .fifo_data_o        (fifo_data),
    .fifo_push_o        (fifo_push),
    .fifo_accept_i      (fifo_accept),
    .status_state_o     (status_state),
    .status_triggered_o (status_triggered),
    .status_overflow_o  (status_overflow),
    .status_count_o     (status_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    cfg_enable  = 1'b0;
    fifo_accept = 1'b1;
    tick();
    tick();
  endtask

  // Model: strobes land at cycle div+1, 2(div+1), ...; the first strobe whose
  // sample meets the trigger rule starts the capture, which lasts 'samples'
  // strobes (forever if 0). Cycle c's outputs are observed just after edge c.
  task automatic run_capture(input string tag, input int n, input int div,
                             input logic [31:0] mask, input logic [31:0] value,
                             input bit edg, input int samples, input bit scramble);
    bit cap [0:199];
    int trig_at, last_at, ncap, cnt;
    bit prev, m, hit, exp_ovf;
    logic [1:0] exp_state;

    for (int c = 0; c < 200; c++) cap[c] = 1'b0;
    trig_at = -1; last_at = -1; ncap = 0; prev = 1'b0;
    for (int s = div + 1; s < n; s += div + 1) begin
      m = ((inp[s] ^ value) & mask) == 32'd0;
      if (trig_at < 0) begin
        hit  = edg ? (m && !prev) : m;
        prev = m;
        if (hit) trig_at = s;
      end
      if (trig_at >= 0 && last_at < 0) begin
        cap[s] = 1'b1;
        ncap++;
        if (samples != 0 && ncap == samples) last_at = s;
      end
    end
    exp_ovf = 1'b0;
    for (int s = 0; s + 1 < n; s++) if (cap[s] && !acc[s + 1]) exp_ovf = 1'b1;

    cfg_clk_div    = div[15:0];
    cfg_trig_mask  = mask;
    cfg_trig_value = value;
    cfg_trig_edge  = edg;
    cfg_samples    = samples;
    accepted = 0;
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      cfg_enable  = 1'b1;
      input_w     = inp[c];
      fifo_accept = acc[c];
      if (c >= 1 && scramble) begin
        cfg_clk_div    = 16'($urandom);
        cfg_trig_mask  = $urandom;
        cfg_trig_value = $urandom;
        cfg_trig_edge  = 1'($urandom);
        cfg_samples    = $urandom;
      end
      if (fifo_push && fifo_accept) accepted++;
      tick();
      cnt += int'(cap[c]);
      exp_state = (last_at >= 0 && c >= last_at) ? 2'd3 :
                  (trig_at >= 0 && c >= trig_at) ? 2'd2 : 2'd1;
      chk({tag, "_push"}, fifo_push, cap[c]);
      if (cap[c]) chk({tag, "_data"}, fifo_data, inp[c]);
      chk({tag, "_state"}, status_state, exp_state);
      chk({tag, "_count"}, status_count, cnt);
    end
    chk({tag, "_trig"}, status_triggered, trig_at >= 0);
    chk({tag, "_ovf"}, status_overflow, exp_ovf);
  endtask

  task automatic fill(input logic [31:0] keep_mask);
    for (int c = 0; c < 200; c++) begin
      inp[c] = $urandom & ~keep_mask;
      acc[c] = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; cfg_enable = 1'b0; cfg_clk_div = '0; cfg_trig_mask = '0;
    cfg_trig_value = '0; cfg_trig_edge = 1'b0; cfg_samples = '0;
    input_w = '0; fifo_accept = 1'b1;
    tick(); tick();
    chk("rst_state", status_state, 0);
    chk("rst_push", fifo_push, 0);
    chk("rst_data", fifo_data, 0);
    chk("rst_count", status_count, 0);
    chk("rst_trig", status_triggered, 0);
    chk("rst_ovf", status_overflow, 0);
    rst = 1'b0;
    go_idle();

    // Level trigger on bit0 rising at cycle 10.
    fill(32'h1);
    for (int c = 10; c < 200; c++) inp[c][0] = 1'b1;
    run_capture("lvl", 20, 0, 32'h1, 32'h1, 1'b0, 4, 1'b1);
    chk("lvl_accepted", accepted, 4);
    go_idle();

    // Divide by 4, mask 0: triggers on the first strobe.
    fill(32'h0);
    run_capture("div", 30, 3, 32'h0, 32'h0, 1'b0, 3, 1'b1);
    chk("div_accepted", accepted, 3);
    go_idle();

    // Edge trigger: bit7 low at arm, rises at cycle 9, falls, rises again.
    fill(32'h80);
    for (int c = 9; c < 15; c++) inp[c][7] = 1'b1;
    for (int c = 21; c < 200; c++) inp[c][7] = 1'b1;
    run_capture("edge", 30, 1, 32'h80, 32'h80, 1'b1, 2, 1'b1);
    go_idle();

    // Edge trigger with the condition already true when armed.
    fill(32'h80);
    for (int c = 0; c < 200; c++) inp[c][7] = 1'b1;
    run_capture("edge0", 12, 1, 32'h80, 32'h80, 1'b1, 2, 1'b1);
    go_idle();

    // Two dropped pushes out of five.
    fill(32'h0);
    acc[3] = 1'b0; acc[4] = 1'b0;
    run_capture("ovf", 15, 0, 32'h0, 32'h0, 1'b0, 5, 1'b1);
    chk("ovf_accepted", accepted, 3);
    go_idle();

    // Continuous capture aborted by enable, then re-armed.
    fill(32'h0);
    acc[4] = 1'b0;
    run_capture("cont", 10, 0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    cfg_enable = 1'b0;
    tick();
    chk("abort_state", status_state, 0);
    chk("abort_push", fifo_push, 0);
    chk("abort_count", status_count, 9);
    chk("abort_ovf", status_overflow, 1);
    chk("abort_trig", status_triggered, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_nopush", fifo_push, 0);
    end
    cfg_enable = 1'b1;
    cfg_trig_mask = 32'hFFFF_FFFF;
    cfg_trig_value = ~input_w;
    cfg_clk_div = 16'd5;
    tick();
    chk("rearm_state", status_state, 1);
    chk("rearm_count", status_count, 0);
    chk("rearm_ovf", status_overflow, 0);
    chk("rearm_trig", status_triggered, 0);
    go_idle();

    // Enable drops on the very strobe that would trigger.
    cfg_clk_div = 16'd2; cfg_trig_mask = 32'h0; cfg_samples = 32'd3;
    cfg_trig_edge = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cfg_enable = 1'b1;
      tick();
    end
    chk("trgabort_armed", status_state, 1);
    cfg_enable = 1'b0;
    tick();
    chk("trgabort_state", status_state, 0);
    chk("trgabort_trig", status_triggered, 0);
    chk("trgabort_push", fifo_push, 0);
    tick();
    chk("trgabort_push2", fifo_push, 0);

    // Synchronous reset in the middle of a continuous capture.
    fill(32'h0);
    run_capture("prerst", 8, 0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    tick();
    chk("mrst_state", status_state, 0);
    chk("mrst_push", fifo_push, 0);
    chk("mrst_data", fifo_data, 0);
    chk("mrst_count", status_count, 0);
    chk("mrst_trig", status_triggered, 0);
    chk("mrst_ovf", status_overflow, 0);
    rst = 1'b0;
    go_idle();

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 200; c++) begin
        inp[c] = $urandom;
        acc[c] = ($urandom_range(0, 3) != 0);
      end
      run_capture("rnd", 60, int'($urandom_range(0, 3)), $urandom & 32'hF,
                  $urandom, 1'($urandom), int'($urandom_range(0, 6)), 1'b1);
      go_idle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
